if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller sitting between the program counter and word-addressed instruction memory. It owns the fetch PC and sequences one outstanding memory request at a time with a request/grant/response handshake. It applies jump redirects, discarding any in-flight response that belongs to the old path. It holds the fetched instruction in a one-entry output register until the decode stage stops stalling.

## Interface
- ADDR_W, 32, fetch PC / memory word-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- jump  in  1  redirect request from execute; highest priority
- jump_addr  in  ADDR_W  redirect target (word address)
- stall  in  1  decode cannot accept; holds the output register
- mem_req  out  1  fetch request, high only in state REQ
- mem_addr  out  ADDR_W  request address, equals pc (combinational)
- mem_gnt  in  1  memory accepts the request this cycle (sampled only in REQ)
- mem_rvalid  in  1  response valid (sampled only in WAIT)
- mem_rdata  in  DATA_W  response data
- pc  out  ADDR_W  current fetch PC
- inst_valid  out  1  output register holds an instruction
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  address the held instruction was fetched from

## Operation
- States: BOOT, REQ, WAIT, OUT. One internal flag: kill.
- Reset (async, immediate):
  - state=BOOT, pc=RESET_PC, kill=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - mem_req=0 and mem_addr=RESET_PC, because they follow state and pc.
- jump has priority over every other event in every state.
- BOOT: spends one cycle with no request.
  - jump: pc<=jump_addr, go to REQ.
  - otherwise: go to REQ.
- REQ: mem_req=1, mem_addr=pc. mem_addr is stable until grant, except on a jump.
  - jump & mem_gnt: pc<=jump_addr, kill<=1, go to WAIT. The granted old-path request is discarded.
  - jump & !mem_gnt: pc<=jump_addr, stay in REQ. The request continues with the new address.
  - mem_gnt: go to WAIT.
- WAIT: mem_req=0.
  - mem_rvalid & (jump | kill): discard the data, kill<=0, go to REQ. On jump, also pc<=jump_addr.
  - mem_rvalid, no jump, kill=0: capture the instruction and go to OUT.
    - inst<=mem_rdata, inst_pc<=pc, inst_valid<=1.
    - pc<=pc+1, modulo 2^ADDR_W, so all-ones wraps to 0.
  - jump & !mem_rvalid: pc<=jump_addr, kill<=1, stay in WAIT.
  - Only one response is ever discarded per grant. A second jump while kill=1 only updates pc.
- OUT: inst_valid=1. inst and inst_pc are held stable.
  - jump: inst_valid<=0, pc<=jump_addr, go to REQ. The held instruction is flushed even if decode is not stalled.
  - !stall: inst_valid<=0, go to REQ. Decode consumes the instruction at this edge.
  - stall: hold everything.
- mem_gnt outside REQ and mem_rvalid outside WAIT are ignored.
  - A response belonging to a request granted before reset is therefore dropped.

## Timing
- Reset is released before edge E0.
  - E0: BOOT to REQ, so mem_req is high in cycle 1.
  - Memory must assert mem_rvalid no earlier than the cycle after the grant.
- Best case with gnt in cycle 1 and rvalid in cycle 2:
  - inst_valid is high in cycle 3.
  - With stall=0, the next mem_req is in cycle 4.
  - Steady-state throughput is one instruction per 3 cycles.
- Redirect latency: a jump sampled at edge E gives pc=jump_addr after E.
  - If the controller is in REQ after E, mem_addr=jump_addr in the next cycle.
- Outputs inst, inst_pc and inst_valid are registered. mem_req and mem_addr are derived from state/pc without added latency.

## Test plan
- Reset with RESET_PC=0, gnt held high, rvalid one cycle after grant, rdata=32'h00A00093 then 32'h00100113, stall=0:
  - mem_addr sequence 0,1,…
  - inst_valid pulses every 3rd cycle with inst_pc 0,1 and the matching data.
- stall high for 4 cycles while in OUT:
  - inst_valid, inst and inst_pc stay constant.
  - mem_req stays low.
  - Fetch resumes one cycle after stall drops.
- jump to 0x40 in the same cycle as mem_gnt for address 5:
  - The next rvalid (data 0xDEAD) is discarded and inst_valid stays 0.
  - mem_addr=0x40 on the next request.
  - The first delivered inst_pc is 0x40.
- jump to 0x80 in WAIT with no rvalid, then rvalid 2 cycles later:
  - The response is dropped and kill clears.
  - The next request is to 0x80.
- PC wrap with RESET_PC set to all-ones:
  - The first fetch is at all-ones and the next at 0.
- Assert rst while in WAIT:
  - All outputs return to their reset values immediately.
  - A late rvalid is ignored.
  - The next fetch is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one memory
// request at a time, drops responses from a redirected path and holds the
// fetched instruction until decode accepts it.
module if_fetch_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    OUT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              kill;
  logic              kill_next;
  logic              valid_next;
  logic              capture;

  // The request and its address follow state and pc with no added latency.
  assign mem_req  = (state == REQ);
  assign mem_addr = pc;

  // Control state, fetch PC, discard flag and output-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      kill       <= kill_next;
      inst_valid <= valid_next;
    end
  end

  // Next-state logic; a jump wins over every other event in every state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    valid_next = inst_valid;
    capture    = 1'b0;
    case (state)
      BOOT: begin
        state_next = REQ;
        if (jump) pc_next = jump_addr;
      end
      REQ: begin
        if (jump) begin
          pc_next = jump_addr;
          if (mem_gnt) begin
            kill_next  = 1'b1;
            state_next = WAIT;
          end
        end else if (mem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (jump || kill) begin
            kill_next  = 1'b0;
            state_next = REQ;
            if (jump) pc_next = jump_addr;
          end else begin
            capture    = 1'b1;
            valid_next = 1'b1;
            pc_next    = pc + ADDR_W'(1);
            state_next = OUT;
          end
        end else if (jump) begin
          pc_next   = jump_addr;
          kill_next = 1'b1;
        end
      end
      OUT: begin
        if (jump) begin
          valid_next = 1'b0;
          pc_next    = jump_addr;
          state_next = REQ;
        end else if (!stall) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Output instruction register, loaded only when a live response arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (capture) begin
      inst    <= mem_rdata;
      inst_pc <= pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: streaming fetch, stall hold, jump
// redirects with response discard, reset in WAIT, and PC wrap-around.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] jump_addr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        rst_w;
  logic        jump_w;
  logic [31:0] jump_addr_w;
  logic        stall_w;
  logic        mem_req_w;
  logic [31:0] mem_addr_w;
  logic        mem_gnt_w;
  logic        mem_rvalid_w;
  logic [31:0] mem_rdata_w;
  logic [31:0] pc_w;
  logic        inst_valid_w;
  logic [31:0] inst_w;
  logic [31:0] inst_pc_w;

  int checks;
  int failures;

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pc(pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst_w), .jump(jump_w), .jump_addr(jump_addr_w), .stall(stall_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_gnt(mem_gnt_w),
    .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w), .pc(pc_w),
    .inst_valid(inst_valid_w), .inst(inst_w), .inst_pc(inst_pc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; jump = 1'b0; jump_addr = '0; stall = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rst_w = 1'b1; jump_w = 1'b0; jump_addr_w = '0; stall_w = 1'b0;
    mem_gnt_w = 1'b0; mem_rvalid_w = 1'b0; mem_rdata_w = '0;

    #2;
    $display("[TB] reset values");
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_pc", pc, 0);
    check_output("rst_inst_valid", inst_valid, 0);
    check_output("rst_inst", inst, 0);
    check_output("rst_inst_pc", inst_pc, 0);

    next_cycle();
    next_cycle();
    rst = 1'b0;
    check_output("boot_mem_req", mem_req, 0);

    $display("[TB] streaming fetch");
    mem_gnt = 1'b1;
    next_cycle();
    check_output("c1_mem_req", mem_req, 1);
    check_output("c1_mem_addr", mem_addr, 0);
    next_cycle();
    check_output("c2_mem_req", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093;
    next_cycle();
    check_output("c3_inst_valid", inst_valid, 1);
    check_output("c3_inst", inst, 32'h00A0_0093);
    check_output("c3_inst_pc", inst_pc, 0);
    check_output("c3_mem_addr", mem_addr, 1);
    mem_rvalid = 1'b0;
    next_cycle();
    check_output("c4_mem_req", mem_req, 1);
    check_output("c4_mem_addr", mem_addr, 1);
    check_output("c4_inst_valid", inst_valid, 0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h0010_0113;
    next_cycle();
    check_output("c6_inst_valid", inst_valid, 1);
    check_output("c6_inst", inst, 32'h0010_0113);
    check_output("c6_inst_pc", inst_pc, 1);

    $display("[TB] stall hold");
    stall = 1'b1; mem_gnt = 1'b0; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output("stall_inst_valid", inst_valid, 1);
      check_output("stall_inst", inst, 32'h0010_0113);
      check_output("stall_inst_pc", inst_pc, 1);
      check_output("stall_mem_req", mem_req, 0);
    end
    mem_rvalid = 1'b0;
    next_cycle();
    check_output("stall_last_valid", inst_valid, 1);
    stall = 1'b0;
    next_cycle();
    check_output("resume_mem_req", mem_req, 1);
    check_output("resume_mem_addr", mem_addr, 2);
    check_output("resume_inst_valid", inst_valid, 0);

    $display("[TB] jump in REQ without grant, then jump with grant");
    jump = 1'b1; jump_addr = 32'h5;
    next_cycle();
    check_output("jreq_mem_req", mem_req, 1);
    check_output("jreq_mem_addr", mem_addr, 5);
    jump_addr = 32'h40; mem_gnt = 1'b1;
    next_cycle();
    check_output("jgnt_mem_req", mem_req, 0);
    check_output("jgnt_mem_addr", mem_addr, 32'h40);
    jump = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
    next_cycle();
    check_output("kill_inst_valid", inst_valid, 0);
    check_output("kill_mem_req", mem_req, 1);
    check_output("kill_mem_addr", mem_addr, 32'h40);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    next_cycle();
    check_output("j40_inst_valid", inst_valid, 1);
    check_output("j40_inst_pc", inst_pc, 32'h40);
    check_output("j40_inst", inst, 32'h1111_1111);
    mem_rvalid = 1'b0;
    next_cycle();
    check_output("j41_mem_addr", mem_addr, 32'h41);
    mem_gnt = 1'b1;
    next_cycle();

    $display("[TB] jump in WAIT without response");
    mem_gnt = 1'b0; jump = 1'b1; jump_addr = 32'h80;
    next_cycle();
    check_output("jwait_mem_req", mem_req, 0);
    check_output("jwait_mem_addr", mem_addr, 32'h80);
    jump = 1'b0;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    next_cycle();
    check_output("jwait_drop_valid", inst_valid, 0);
    check_output("jwait_req", mem_req, 1);
    check_output("jwait_req_addr", mem_addr, 32'h80);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    next_cycle();
    check_output("j80_inst_valid", inst_valid, 1);
    check_output("j80_inst_pc", inst_pc, 32'h80);
    check_output("j80_inst", inst, 32'h2222_2222);
    mem_rvalid = 1'b0;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();

    $display("[TB] reset while in WAIT");
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check_output("rwait_mem_req", mem_req, 0);
    check_output("rwait_mem_addr", mem_addr, 0);
    check_output("rwait_inst_valid", inst_valid, 0);
    check_output("rwait_inst", inst, 0);
    check_output("rwait_inst_pc", inst_pc, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check_output("rwait_req", mem_req, 1);
    check_output("rwait_addr", mem_addr, 0);
    next_cycle();
    check_output("rwait_late_valid", inst_valid, 0);
    check_output("rwait_still_req", mem_req, 1);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    next_cycle();
    check_output("rwait_inst_valid2", inst_valid, 1);
    check_output("rwait_inst_pc2", inst_pc, 0);
    check_output("rwait_inst2", inst, 32'h3333_3333);
    mem_rvalid = 1'b0;

    $display("[TB] pc wrap from all-ones");
    rst_w = 1'b0;
    check_output("wrap_boot_addr", mem_addr_w, 32'hFFFF_FFFF);
    mem_gnt_w = 1'b1;
    next_cycle();
    check_output("wrap_req", mem_req_w, 1);
    check_output("wrap_addr0", mem_addr_w, 32'hFFFF_FFFF);
    next_cycle();
    mem_gnt_w = 1'b0; mem_rvalid_w = 1'b1; mem_rdata_w = 32'hAAAA_5555;
    next_cycle();
    check_output("wrap_inst_pc", inst_pc_w, 32'hFFFF_FFFF);
    check_output("wrap_inst", inst_w, 32'hAAAA_5555);
    check_output("wrap_pc", pc_w, 0);
    mem_rvalid_w = 1'b0;
    next_cycle();
    check_output("wrap_req2", mem_req_w, 1);
    check_output("wrap_addr1", mem_addr_w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
